// File: rtl/ps2_seq_pkg.sv
// ps2_seq_pkg
//   Shared types and constants for the PS/2 scan-code sequencer.
//   - state_e : sequencer FSM states
//   - evt_t   : one key event {code, ext, brk} as stored in the event FIFO
//   - PS2_*   : prefix and device-status byte values
//   - is_status(): true for bytes the keyboard sends as status, not keys
package ps2_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0
   } state_e;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR_LO = 8'h00;
   localparam logic [7:0] PS2_ERR_HI = 8'hFF;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } evt_t;

   function automatic logic is_status(input logic [7:0] b);
      return b inside {PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR_LO, PS2_ERR_HI};
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
//   Synchronous FIFO of evt_t entries, DEPTH deep (power of two, >= 2).
//   A push into a full FIFO is accepted only if a pop happens in the same
//   cycle; a pop from an empty FIFO is ignored. The head is zero while empty.
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   push_i       write push_data_i this cycle
//   push_data_i  event to store
//   pop_i        remove the head this cycle
//   head_o       oldest stored event
//   full_o       DEPTH entries held
//   empty_o      no entries held
module ps2_evt_fifo
   import ps2_seq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  evt_t push_data_i,
   input  logic pop_i,
   output evt_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   evt_t        mem_q [DEPTH];
   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are valid, and leaving the array unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Merges raw PS/2 scan bytes (E0 extended and F0 break prefixes plus the
//   code byte) into key events, filters device status bytes in IDLE, aborts
//   stalled or corrupted sequences with a proto_err pulse, and queues events
//   in a valid/ready FIFO.
// Optional feature: define KEY_STATE_EN to keep a 128-bit held-key bitmap
//   for non-extended codes below 0x80, queried through key_q/key_down.
//   Without it key_down is tied to 0 and key_q is ignored.
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   rx_byte, rx_valid, rx_err byte strobe / frame-error strobe from receiver
//   evt_code/ext/brk, evt_valid, evt_ready  FIFO head with handshake
//   ovf, ovf_clr              sticky drop flag and its clear
//   proto_err                 one-cycle pulse on sequence error or timeout
//   busy                      sequencer is mid-sequence
//   key_q, key_down           held-key query (KEY_STATE_EN only)
module ps2_scan_sequencer
   import ps2_seq_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       proto_err,
   output logic       busy,
   input  logic [6:0] key_q,
   output logic       key_down
);

   localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             proto_err_q, proto_err_d;
   logic             ovf_q, ovf_d;
   logic             push, pop, fifo_full, fifo_empty, drop;
   evt_t             push_evt, head;

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      proto_err_d = 1'b0;
      push        = 1'b0;
      push_evt    = '{code: rx_byte, ext: 1'b0, brk: 1'b0};

      if (rx_err) begin
         // A bad frame poisons any partial sequence; the coincident byte is ignored.
         state_d     = IDLE;
         proto_err_d = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (rx_byte == PS2_EXT)      state_d = GOT_E0;
               else if (rx_byte == PS2_BRK) state_d = GOT_F0;
               else if (!is_status(rx_byte)) push  = 1'b1;
            end
            GOT_E0: begin
               if (rx_byte == PS2_BRK) begin
                  state_d = GOT_E0F0;
               end else if (rx_byte == PS2_EXT) begin
                  proto_err_d = 1'b1;
               end else begin
                  push         = 1'b1;
                  push_evt.ext = 1'b1;
                  state_d      = IDLE;
               end
            end
            GOT_F0, GOT_E0F0: begin
               // A fresh prefix here means the previous sequence was cut
               // short; report it and start over from that prefix.
               if (rx_byte == PS2_EXT) begin
                  proto_err_d = 1'b1;
                  state_d     = GOT_E0;
               end else if (rx_byte == PS2_BRK) begin
                  proto_err_d = 1'b1;
                  state_d     = GOT_F0;
               end else begin
                  push         = 1'b1;
                  push_evt.ext = (state_q == GOT_E0F0);
                  push_evt.brk = 1'b1;
                  state_d      = IDLE;
               end
            end
         endcase
      end else if (state_q != IDLE && timer_q == TMR_LAST) begin
         state_d     = IDLE;
         proto_err_d = 1'b1;
      end
   end

   assign timer_d = (rx_valid || state_q == IDLE) ? '0 : timer_q + TMR_ONE;

   assign pop   = evt_valid && evt_ready;
   assign drop  = push && fifo_full && !pop;
   // A drop in the same cycle as ovf_clr keeps the flag set.
   assign ovf_d = drop || (ovf_q && !ovf_clr);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         proto_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         proto_err_q <= proto_err_d;
         ovf_q       <= ovf_d;
      end
   end

   ps2_evt_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_data_i(push_evt),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_brk   = head.brk;
   assign evt_valid = !fifo_empty;
   assign proto_err = proto_err_q;
   assign ovf       = ovf_q;
   assign busy      = (state_q != IDLE);

`ifdef KEY_STATE_EN
   logic [127:0] held_q;

   // Tracks the key on the push request itself, so a make/break still
   // updates the bitmap when the event is lost to overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_q <= '0;
      end else if (push && !push_evt.ext && !push_evt.code[7]) begin
         held_q[push_evt.code[6:0]] <= !push_evt.brk;
      end
   end

   assign key_down = held_q[key_q];
`else
   logic unused_key_q;
   assign unused_key_q = ^key_q;
   assign key_down     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer
//   Self-checking bench for ps2_scan_sequencer (DEPTH=8, TIMEOUT_CYC=50000).
//   Compile with +define+KEY_STATE_EN to exercise the held-key bitmap.
module tb_ps2_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_valid;
   logic       evt_ready;
   logic       ovf;
   logic       ovf_clr;
   logic       proto_err;
   logic       busy;
   logic [6:0] key_q;
   logic       key_down;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } tb_evt_t;

   // One stimulus step and what must be visible one cycle later.
   typedef struct packed {
      logic [7:0] b;
      logic       v;
      logic       e;
      logic       perr;
      logic       busy;
      logic       emit;
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } vec_t;

   tb_evt_t exp_q[$];
   vec_t    vecs[$];

   ps2_scan_sequencer #(
      .DEPTH      (8),
      .TIMEOUT_CYC(50000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .evt_code (evt_code),
      .evt_ext  (evt_ext),
      .evt_brk  (evt_brk),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .proto_err(proto_err),
      .busy     (busy),
      .key_q    (key_q),
      .key_down (key_down)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare every accepted FIFO head against the oldest expected event.
   always @(negedge clk) begin
      #1;
      if (!rst && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_evt", {22'd0, evt_code, evt_ext, evt_brk}, 32'h0);
         end else begin
            tb_evt_t e;
            e = exp_q.pop_front();
            check("evt", {22'd0, evt_code, evt_ext, evt_brk}, {22'd0, e});
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
      exp_q.push_back('{code: code, ext: ext, brk: brk});
   endtask

   task automatic drain();
      int n;
      n = 0;
      evt_ready = 1'b1;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", {31'd0, exp_q.size() == 0}, 32'd1);
      @(negedge clk);
      #1;
      check("drain_empty", {31'd0, evt_valid}, 32'd0);
   endtask

   task automatic add(input logic [7:0] b, input logic v, input logic e, input logic perr,
                      input logic bz, input logic emit, input logic [7:0] code,
                      input logic ext, input logic brk);
      vecs.push_back('{b: b, v: v, e: e, perr: perr, busy: bz, emit: emit,
                       code: code, ext: ext, brk: brk});
   endtask

   initial begin
      int cycles;
      logic kd_exp;

      rst = 1'b1; rx_byte = '0; rx_valid = 1'b0; rx_err = 1'b0;
      evt_ready = 1'b0; ovf_clr = 1'b0; key_q = '0;

      //      byte   v     e     perr  busy  emit  code   ext   brk
      add(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1);
      add(8'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1);
      add(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hFA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hE0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hE0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0);
      add(8'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
      add(8'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hFA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFA, 1'b1, 1'b0);
      add(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h29, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0);
      add(8'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      add(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
      check("rst_evt_head", {22'd0, evt_code, evt_ext, evt_brk}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_proto_err", {31'd0, proto_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_key_down", {31'd0, key_down}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single-byte steps with the consumer always ready
      evt_ready = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rx_byte  = vecs[i].b;
         rx_valid = vecs[i].v;
         rx_err   = vecs[i].e;
         if (vecs[i].emit) expect_evt(vecs[i].code, vecs[i].ext, vecs[i].brk);
         @(negedge clk);
         rx_valid = 1'b0;
         rx_err   = 1'b0;
         #1;
         check($sformatf("v%0d_perr", i), {31'd0, proto_err}, {31'd0, vecs[i].perr});
         check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
         check($sformatf("v%0d_lat", i), {31'd0, evt_valid}, {31'd0, vecs[i].emit});
      end
      drain();

      // Overflow: fill with the consumer stalled
      evt_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_evt(8'h10 + 8'(i), 1'b0, 1'b0);
         send(8'h10 + 8'(i));
         #1;
         if (i == 7) check("ovf_at_8", {31'd0, ovf}, 32'd0);
      end
      check("ovf_at_9", {31'd0, ovf}, 32'd1);
      check("full_head", {22'd0, evt_code, evt_ext, evt_brk}, {22'd0, 8'h10, 2'b00});
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #1;
      check("ovf_clr", {31'd0, ovf}, 32'd0);

      // Full FIFO: push and pop in the same cycle
      @(negedge clk);
      rx_byte = 8'h19; rx_valid = 1'b1; evt_ready = 1'b1;
      expect_evt(8'h19, 1'b0, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0; evt_ready = 1'b0;
      #1;
      check("pushpop_ovf", {31'd0, ovf}, 32'd0);
      check("pushpop_head", {24'd0, evt_code}, 32'h11);

      // Still full: next push is dropped
      send(8'h1A);
      #1;
      check("still_full_ovf", {31'd0, ovf}, 32'd1);

      // Drop coinciding with ovf_clr keeps the flag
      @(negedge clk);
      rx_byte = 8'h1B; rx_valid = 1'b1; ovf_clr = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; ovf_clr = 1'b0;
      #1;
      check("drop_beats_clr", {31'd0, ovf}, 32'd1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      drain();

      // Timeout after a lone E0 prefix
      send(8'hE0);
      #1;
      check("to_busy", {31'd0, busy}, 32'd1);
      cycles = 0;
      do begin
         @(negedge clk);
         #1;
         cycles++;
      end while (!proto_err && cycles < 50100);
      check("to_cycles", cycles, 32'd50000);
      check("to_idle", {31'd0, busy}, 32'd0);
      check("to_empty", {31'd0, evt_valid}, 32'd0);
      expect_evt(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      #1;
      check("to_after_perr", {31'd0, proto_err}, 32'd0);
      drain();

      // Held-key bitmap
`ifdef KEY_STATE_EN
      kd_exp = 1'b1;
`else
      kd_exp = 1'b0;
`endif
      key_q = 7'h1C;
      expect_evt(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      #1;
      check("key_make", {31'd0, key_down}, {31'd0, kd_exp});
      expect_evt(8'h1C, 1'b1, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h1C);
      #1;
      check("key_ext_brk_ignored", {31'd0, key_down}, {31'd0, kd_exp});
      expect_evt(8'h1C, 1'b0, 1'b1);
      send(8'hF0); send(8'h1C);
      #1;
      check("key_break", {31'd0, key_down}, 32'd0);
      expect_evt(8'h1C, 1'b1, 1'b0);
      send(8'hE0); send(8'h1C);
      #1;
      check("key_ext_make", {31'd0, key_down}, 32'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
